multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main controller for the multicycle RV32I core. Decodes op/funct3 from the IR and steps the
//  shared ALU/memory datapath through fetch-decode-execute. Drives imm_src into the immediate
//  generator, plus all write enables and mux selects. Adds a memory ready handshake with a
//  wait-state timeout, and a sticky trap on illegal opcodes.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles allowed per memory access before trap (1..255)
//  TO_W         8   width of the wait counter; must satisfy 2**TO_W > MEM_TIMEOUT
// PORTS
//  clk          in   1  core clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  op           in   7  instr[6:0] from IR
//  funct3       in   3  instr[14:12]
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes the access this cycle
//  mem_req      out  1  memory access in progress (FETCH/MEMREAD/MEMWRITE)
//  adr_src      out  1  0=PC, 1=ALUOut as memory address
//  mem_write    out  1  store strobe
//  ir_write     out  1  IR/oldPC load
//  pc_write     out  1  PC load
//  reg_write    out  1  register file write
//  result_src   out  2  00=ALUOut 01=Data 10=ALUResult
//  alu_src_a    out  2  00=PC 01=oldPC 10=rs1 11=zero
//  alu_src_b    out  2  00=rs2 01=imm 10=const 4
//  alu_op       out  2  00=add 01=sub(branch) 10=funct-decoded
//  imm_src      out  3  000 I, 001 S, 010 B, 011 U, 100 J (combinational from op)
//  trap         out  1  sticky: illegal opcode or memory timeout
// BEHAVIOUR
//  - States: RESET FETCH DECODE MEMADR MEMREAD MEMWB MEMWRITE EXECR EXECI ALUWB BRANCH JAL TRAP
//    (+LUI AUIPC). Moore outputs decoded from state; any signal not listed below is 0.
//  - Reset: async to RESET, wait counter=0. In RESET all outputs are 0 except imm_src.
//    RESET->FETCH on the first clk edge after rst_n deasserts. Reset mid-access aborts cleanly.
//  - FETCH: mem_req, adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10.
//    ir_write=pc_write=1 only in the cycle mem_ready=1, then ->DECODE; otherwise hold.
//  - DECODE: src_a=01, src_b=01, alu_op=00 (branch/jump target). Next state by op:
//    0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH,
//    1101111->JAL, 0110111/0010111->LUI/AUIPC (macro only), any other op->TRAP.
//  - MEMADR: src_a=10, src_b=01, alu_op=00; goes to MEMREAD for lw, MEMWRITE for sw.
//  - MEMREAD: mem_req, adr_src=1; goes to MEMWB when mem_ready=1.
//    MEMWB: result_src=01, reg_write; then ->FETCH.
//  - MEMWRITE: mem_req, adr_src=1; mem_write=1 only in the mem_ready cycle; then ->FETCH.
//  - EXECR: src_a=10, src_b=00, alu_op=10. EXECI: src_a=10, src_b=01, alu_op=10. Both ->ALUWB.
//  - ALUWB: result_src=00, reg_write; ->FETCH.
//  - BRANCH: src_a=10, src_b=00, alu_op=01, result_src=00.
//    pc_write = zero ^ funct3[0] (beq/bne); ->FETCH.
//  - JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_write=1; ->ALUWB (rd=PC+4).
//  - Wait counter: cleared on entry to every memory state. Increments each cycle mem_req=1
//    and mem_ready=0. When count==MEM_TIMEOUT and mem_ready=0: ->TRAP with no write strobe.
//    If mem_ready=1 in that same cycle, completion wins.
//  - TRAP: all outputs 0 except trap=1. Held until reset.
//  - Latency with mem_ready tied 1: R/I=4, lw=5, sw=4, branch=3, jal=4 cycles.
// CONFIGURATION
//  RV_UTYPE_EN defined: adds states LUI (src_a=11, src_b=01, alu_op=00) and AUIPC
//    (src_a=01, src_b=01, alu_op=00); both ->ALUWB. imm_src=011 for these opcodes.
//  RV_UTYPE_EN undefined: 0110111/0010111 are illegal ->TRAP; alu_src_a never drives 11.
// TESTING
//  - Reset: rst_n=0 mid-MEMREAD -> RESET immediately, outputs 0; release -> FETCH next edge.
//  - add (0x00B50533), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; reg_write one cycle; back to FETCH.
//  - lw, mem_ready low 3 cycles in MEMREAD -> state holds 3 cycles; MEMWB reg_write=1 once.
//  - bne (funct3=001) with zero=0 -> pc_write=1 in BRANCH; with zero=1 -> pc_write=0.
//  - sw, mem_ready stuck 0, MEM_TIMEOUT=15 -> TRAP after 15 wait cycles; mem_write never 1.
//  - lui 0x12345 -> with macro: LUI,ALUWB and imm_src=011; without macro: TRAP, trap=1.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
// Bundles the controller's instruction/status inputs and its datapath
// control outputs.
//   master : the controller side (drives the control outputs)
//   slave  : the datapath/memory side (drives op, funct3, zero, mem_ready)
// Signals
//   op[6:0], funct3[2:0]  instruction fields from the IR
//   zero                  ALU zero flag
//   mem_ready             memory completes the access this cycle
//   mem_req, adr_src, mem_write, ir_write, pc_write, reg_write
//   result_src[1:0], alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0]
//   imm_src[2:0]          immediate format select
//   trap                  sticky fault indication
// ---------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] imm_src;
  logic       trap;

  modport master (
    input  op, funct3, zero, mem_ready,
    output mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, trap
  );

  modport slave (
    output op, funct3, zero, mem_ready,
    input  mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, trap
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Main controller of a multicycle RV32I core. Steps the shared ALU/memory
// datapath through fetch-decode-execute, waits on a memory ready handshake
// with a bounded wait-state count, and enters a sticky trap on an illegal
// opcode or a memory access that never completes.
// Ports
//   clk    : core clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : multicycle_ctrl_fsm_if.master (IR fields, flags, control outputs)
// Parameters
//   MEM_TIMEOUT : wait cycles tolerated per memory access before trap (1..255)
//   TO_W        : wait counter width, 2**TO_W must exceed MEM_TIMEOUT
// Configuration macro
//   RV_UTYPE_EN : adds LUI/AUIPC states; when undefined those opcodes trap.
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_ctrl_fsm_if.master bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef RV_UTYPE_EN
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`endif
  localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP, S_LUI, S_AUIPC
  } state_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

  logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, trap;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_gen;
  logic       timeout;
  logic       unused_funct3;

  // Only funct3[0] matters: it distinguishes bne from beq.
  assign unused_funct3 = ^bus.funct3[2:1];
  assign timeout       = (wait_cnt_q == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Counter restarts on every state change, so each memory state begins its
  // access at zero; it only advances while a request is stalled.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_req && !bus.mem_ready) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    trap       = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        // Ready takes priority over the timeout in the final wait cycle.
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          state_d  = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
`ifdef RV_UTYPE_EN
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
`endif
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready)  state_d = S_MEMWB;
        else if (timeout)   state_d = S_TRAP;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) begin
          mem_write = 1'b1;
          state_d   = S_FETCH;
        end else if (timeout) begin
          state_d   = S_TRAP;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = bus.zero ^ bus.funct3[0];
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
`ifdef RV_UTYPE_EN
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
`endif
      S_TRAP:  trap    = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  // Immediate format follows the IR opcode directly, independent of state.
  always_comb begin
    imm_gen = 3'b000;
    case (bus.op)
      OP_STORE:  imm_gen = 3'b001;
      OP_BRANCH: imm_gen = 3'b010;
      OP_JAL:    imm_gen = 3'b100;
`ifdef RV_UTYPE_EN
      OP_LUI, OP_AUIPC: imm_gen = 3'b011;
`endif
      default:   imm_gen = 3'b000;
    endcase
  end

  assign bus.mem_req    = mem_req;
  assign bus.adr_src    = adr_src;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.reg_write  = reg_write;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.trap       = trap;
  // A trapped core drives nothing but the trap flag.
  assign bus.imm_src    = (state_q == S_TRAP) ? 3'b000 : imm_gen;

endmodule
